// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: VGA scan-out reads have absolute priority on a single-port RAM,
// pixel-writer words queue in a small FIFO and drain in cycles scan-out leaves free.
module vga_fb_arbiter #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    output logic [DATA_W-1:0] pix_rgb,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned FB_W     = H_ACTIVE >> SCALE_SHIFT;
    localparam int unsigned FB_H     = V_ACTIVE >> SCALE_SHIFT;
    localparam int unsigned FB_WORDS = FB_W * FB_H;
    localparam int unsigned BLK_MASK = (32'd1 << SCALE_SHIFT) - 32'd1;
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    wr_entry_t         fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_ready_q, wr_ready_d;
    logic [7:0]        drop_q, drop_d;
    logic              act1_q, act1_d;
    logic              slot1_q, slot1_d;
    logic [DATA_W-1:0] blk_q, blk_d;
    logic [DATA_W-1:0] pix_q, pix_d;

    logic              active_c;
    logic              slot_c;
    logic [ADDR_W-1:0] scan_addr_c;
    logic              accept_c;
    logic              in_range_c;
    logic              push_c;
    logic              pop_c;
    wr_entry_t         head_c;

    // Scan position decode: a slot is the first pixel of each visible block
    always_comb begin
        active_c    = (32'(hcount) < H_ACTIVE) && (32'(vcount) < V_ACTIVE);
        slot_c      = active_c && ((32'(hcount) & BLK_MASK) == 32'd0);
        scan_addr_c = ADDR_W'((32'(vcount) >> SCALE_SHIFT) * FB_W + (32'(hcount) >> SCALE_SHIFT));
    end

    always_comb begin
        head_c     = fifo_q[rd_ptr_q];
        accept_c   = wr_valid && wr_ready_q;
        in_range_c = 32'(wr_addr) < FB_WORDS;
        push_c     = accept_c && in_range_c;
        pop_c      = !slot_c && (count_q != '0);
    end

    // RAM port mux; held idle while reset is asserted so no access escapes
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst_n) begin
            if (slot_c) begin
                mem_en   = 1'b1;
                mem_addr = scan_addr_c;
            end else if (pop_c) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = head_c.addr;
                mem_wdata = head_c.data;
            end
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        wr_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
        if (accept_c && !in_range_c && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    end

    // Two-stage pixel pipeline; RAM data arrives one cycle after the slot
    always_comb begin
        act1_d  = active_c;
        slot1_d = slot_c;
        blk_d   = slot1_q ? mem_rdata : blk_q;
        pix_d   = act1_q ? (slot1_q ? mem_rdata : blk_q) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            wr_ready_q <= 1'b0;
            drop_q     <= 8'd0;
            act1_q     <= 1'b0;
            slot1_q    <= 1'b0;
            blk_q      <= '0;
            pix_q      <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            wr_ready_q <= wr_ready_d;
            drop_q     <= drop_d;
            act1_q     <= act1_d;
            slot1_q    <= slot1_d;
            blk_q      <= blk_d;
            pix_q      <= pix_d;
        end
    end

    // Storage needs no reset: validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (push_c) fifo_q[wr_ptr_q] <= '{addr: wr_addr, data: wr_data};
    end

    assign pix_rgb  = pix_q;
    assign wr_ready = wr_ready_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural single-port RAM model.
module tb_vga_fb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [11:0] pix_rgb;
    logic        wr_valid;
    logic        wr_ready;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        mem_en;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;
    int snap;

    logic [11:0] ram [0:32767] = '{default: 12'h000};

    vga_fb_arbiter dut (
        .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .pix_rgb(pix_rgb),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Words 0 and 1 read as fixed colours; everything else reflects RAM writes
    function automatic logic [11:0] rd_word(input logic [14:0] a);
        if (a == 15'd0) return 12'hF19;
        if (a == 15'd1) return 12'h0AB;
        return ram[a];
    endfunction

    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= rd_word(mem_addr);
        if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_seen <= wr_seen + 1;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    task automatic test_reset();
        rst_n = 1'b0; hcount = 10'd0; vcount = 10'd0;
        wr_valid = 1'b1; wr_addr = 15'd5; wr_data = 12'h123; mem_rdata = 12'h000;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (pix_rgb !== 12'h000) begin errors++; $display("FAIL rst_pix: got %0h required 0", pix_rgb); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %0b required 0", mem_en); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %0b required 0", mem_we); end
        checks++; if (mem_addr !== 15'd0) begin errors++; $display("FAIL rst_mem_addr: got %0d required 0", mem_addr); end
        checks++; if (mem_wdata !== 12'h000) begin errors++; $display("FAIL rst_mem_wdata: got %0h required 0", mem_wdata); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready: got %0b required 0", wr_ready); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_drop: got %0d required 0", drop_cnt); end
        wr_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 15'd0) begin
            errors++; $display("FAIL first_slot: got en=%0b we=%0b addr=%0d required en=1 we=0 addr=0", mem_en, mem_we, mem_addr); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %0b required 0", wr_ready); end
    endtask

    task automatic test_first_block();
        logic [11:0] exp;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            hcount = 10'(k);
            #1;
            exp = (k < 2) ? 12'h000 : ((k <= 5) ? 12'hF19 : 12'h0AB);
            checks++; if (pix_rgb !== exp) begin errors++; $display("FAIL pix_h%0d: got %0h required %0h", k, pix_rgb, exp); end
            if (k == 1) begin
                checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %0b required 1", wr_ready); end
            end
        end
    endtask

    task automatic test_scan_write();
        @(posedge clk); #1;
        hcount = 10'd4; vcount = 10'd8; wr_valid = 1'b1; wr_addr = 15'd7; wr_data = 12'h060;
        #1;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 15'd321) begin
            errors++; $display("FAIL slot_4_8: got en=%0b we=%0b addr=%0d required 1 0 321", mem_en, mem_we, mem_addr); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL ready_4_8: got %0b required 1", wr_ready); end
        @(posedge clk); #1;
        hcount = 10'd5; wr_valid = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd7 || mem_wdata !== 12'h060) begin
            errors++; $display("FAIL write_h5: got en=%0b we=%0b addr=%0d data=%0h required 1 1 7 060", mem_en, mem_we, mem_addr, mem_wdata); end
        for (int h = 6; h <= 7; h++) begin
            @(posedge clk); #1;
            hcount = 10'(h);
            #1;
            checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL idle_h%0d: got en=%0b required 0", h, mem_en); end
        end
        @(posedge clk); #1;
        hcount = 10'd8;
        #1;
        checks++; if (mem_addr !== 15'd322 || mem_we !== 1'b0) begin
            errors++; $display("FAIL slot_8_8: got addr=%0d we=%0b required 322 0", mem_addr, mem_we); end
        checks++; if (ram[7] !== 12'h060) begin errors++; $display("FAIL ram7: got %0h required 060", ram[7]); end
    endtask

    task automatic test_fifo_full();
        logic [14:0] ea;
        logic [11:0] ed;
        @(posedge clk); #1;
        hcount = 10'd0; vcount = 10'd0;
        for (int j = 0; j < 6; j++) begin
            wr_valid = 1'b1; wr_addr = 15'(100 + j); wr_data = 12'(257 + j);
            #1;
            checks++; if (wr_ready !== (j < 4)) begin errors++; $display("FAIL full_ready_%0d: got %0b required %0b", j, wr_ready, (j < 4)); end
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL full_no_we_%0d: got %0b required 0", j, mem_we); end
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        for (int h = 1; h <= 5; h++) begin
            hcount = 10'(h);
            #1;
            if (h == 4) begin
                checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL drain_slot: got we=%0b required 0", mem_we); end
            end else begin
                ea = 15'(100 + ((h == 5) ? 3 : h - 1));
                ed = 12'(257 + ((h == 5) ? 3 : h - 1));
                checks++; if (mem_we !== 1'b1 || mem_addr !== ea || mem_wdata !== ed) begin
                    errors++; $display("FAIL drain_h%0d: got we=%0b addr=%0d data=%0h required 1 %0d %0h", h, mem_we, mem_addr, mem_wdata, ea, ed); end
            end
            if (h == 2) begin
                checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL ready_reopen: got %0b required 1", wr_ready); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_drop();
        hcount = 10'd700; vcount = 10'd100;
        wr_valid = 1'b1; wr_addr = 15'd19200; wr_data = 12'hFFF;
        snap = wr_seen;
        #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL drop_ready: got %0b required 1", wr_ready); end
        @(posedge clk); #1;
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_one: got %0d required 1", drop_cnt); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL drop_no_access: got %0b required 0", mem_en); end
        repeat (255) @(posedge clk);
        #1;
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_256: got %0d required 255", drop_cnt); end
        @(posedge clk); #1;
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat: got %0d required 255", drop_cnt); end
        checks++; if (wr_seen !== snap) begin errors++; $display("FAIL drop_writes: got %0d required %0d", wr_seen, snap); end
        wr_valid = 1'b0;
    endtask

    task automatic test_blanking_drain();
        @(posedge clk); #1;
        hcount = 10'd0; vcount = 10'd0; wr_valid = 1'b1; wr_addr = 15'd200; wr_data = 12'hAAA;
        @(posedge clk); #1;
        wr_addr = 15'd201; wr_data = 12'h555;
        @(posedge clk); #1;
        wr_valid = 1'b0; hcount = 10'd700; vcount = 10'd100;
        #1;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 15'd200 || mem_wdata !== 12'hAAA) begin
            errors++; $display("FAIL blank_w0: got we=%0b addr=%0d data=%0h required 1 200 AAA", mem_we, mem_addr, mem_wdata); end
        @(posedge clk); #2;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 15'd201 || mem_wdata !== 12'h555) begin
            errors++; $display("FAIL blank_w1: got we=%0b addr=%0d data=%0h required 1 201 555", mem_we, mem_addr, mem_wdata); end
        @(posedge clk); #2;
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL blank_idle: got %0b required 0", mem_en); end
        checks++; if (pix_rgb !== 12'h000) begin errors++; $display("FAIL blank_pix: got %0h required 0", pix_rgb); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        hcount = 10'd0; vcount = 10'd0; wr_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            wr_addr = 15'(300 + j); wr_data = 12'(769 + j);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        snap = wr_seen;
        rst_n = 1'b0; hcount = 10'd700; vcount = 10'd100;
        #1;
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 15'd0 || mem_wdata !== 12'h000) begin
            errors++; $display("FAIL mid_rst_mem: got en=%0b we=%0b addr=%0d data=%0h required all 0", mem_en, mem_we, mem_addr, mem_wdata); end
        checks++; if (wr_ready !== 1'b0 || pix_rgb !== 12'h000 || drop_cnt !== 8'd0) begin
            errors++; $display("FAIL mid_rst_regs: got ready=%0b pix=%0h drop=%0d required 0 0 0", wr_ready, pix_rgb, drop_cnt); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (wr_seen !== snap) begin errors++; $display("FAIL mid_rst_writes: got %0d required %0d", wr_seen, snap); end
        checks++; if (ram[300] !== 12'h000 || ram[302] !== 12'h000) begin
            errors++; $display("FAIL mid_rst_ram: got %0h %0h required 0 0", ram[300], ram[302]); end
        checks++; if (mem_en !== 1'b0 || wr_ready !== 1'b1) begin
            errors++; $display("FAIL mid_rst_after: got en=%0b ready=%0b required 0 1", mem_en, wr_ready); end
    endtask

    initial begin
        test_reset();
        test_first_block();
        test_scan_write();
        test_fifo_full();
        test_drop();
        test_blanking_drain();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
